// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter/sequencer with registered broadcast (optional CDB_PERF_CNT_EN counters)
module cdb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = 16,
   parameter int TAG_W   = 3,
   parameter int REG_AW  = 3,
   parameter int MEM_AW  = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [4*NUM_REQ-1:0]      req_op,
   input  logic [TAG_W*NUM_REQ-1:0]  req_tag,
   input  logic [REG_AW*NUM_REQ-1:0] req_dest,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   input  logic [DATA_W*NUM_REQ-1:0] req_sdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic                      rf_we,
   output logic [REG_AW-1:0]         rf_addr,
   output logic [DATA_W-1:0]         rf_data,
   output logic                      mem_we,
   output logic [MEM_AW-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_data
`ifdef CDB_PERF_CNT_EN
   ,
   output logic [31:0]               busy_cnt,
   output logic [31:0]               conflict_cnt
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_SD  = 4'b0011;
   localparam logic [3:0] OP_MUL = 4'b0100;

   logic [PW-1:0]     ptr_q, ptr_d;
   logic              cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
   logic              rf_we_q, rf_we_d;
   logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic              mem_we_q, mem_we_d;
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_q, mem_data_d;

   logic [NUM_REQ-1:0] grant;
   logic               xfer;
   logic [PW-1:0]      sel_idx;
   logic [3:0]         sel_op;
   logic [TAG_W-1:0]   sel_tag;
   logic [REG_AW-1:0]  sel_dest;
   logic [DATA_W-1:0]  sel_data;
   logic [DATA_W-1:0]  sel_sdata;
   logic               is_rf;
   logic               is_sd;
   int                 idx;

   // Rotating priority search starting just after the last granted producer; also muxes out its payload.
   always_comb begin
      grant     = '0;
      xfer      = 1'b0;
      sel_idx   = ptr_q;
      sel_op    = '0;
      sel_tag   = '0;
      sel_dest  = '0;
      sel_data  = '0;
      sel_sdata = '0;
      idx       = 0;
      if (!reset && !flush) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!xfer && req_valid[idx]) begin
               xfer       = 1'b1;
               grant[idx] = 1'b1;
               sel_idx    = idx[PW-1:0];
               sel_op     = req_op[idx*4 +: 4];
               sel_tag    = req_tag[idx*TAG_W +: TAG_W];
               sel_dest   = req_dest[idx*REG_AW +: REG_AW];
               sel_data   = req_data[idx*DATA_W +: DATA_W];
               sel_sdata  = req_sdata[idx*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign req_ready = grant;

   // Opcode decode and next-state for the broadcast; payload registers hold when their strobe is idle.
   always_comb begin
      is_rf       = (sel_op == OP_ADD) || (sel_op == OP_SUB) ||
                    (sel_op == OP_MUL) || (sel_op == OP_LD);
      is_sd       = (sel_op == OP_SD);
      ptr_d       = xfer ? sel_idx : ptr_q;
      cdb_valid_d = xfer;
      cdb_tag_d   = xfer ? sel_tag  : cdb_tag_q;
      cdb_data_d  = xfer ? sel_data : cdb_data_q;
      rf_we_d     = xfer && is_rf;
      rf_addr_d   = (xfer && is_rf) ? sel_dest : rf_addr_q;
      rf_data_d   = (xfer && is_rf) ? sel_data : rf_data_q;
      mem_we_d    = xfer && is_sd;
      mem_addr_d  = (xfer && is_sd) ? sel_data[MEM_AW-1:0] : mem_addr_q;
      mem_data_d  = (xfer && is_sd) ? sel_sdata : mem_data_q;
   end

   // Broadcast and pointer registers; reset returns priority to producer 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q       <= PTR_RST;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         rf_we_q     <= 1'b0;
         rf_addr_q   <= '0;
         rf_data_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         rf_we_q     <= rf_we_d;
         rf_addr_q   <= rf_addr_d;
         rf_data_q   <= rf_data_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_data  = cdb_data_q;
   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;

`ifdef CDB_PERF_CNT_EN
   logic [31:0] busy_cnt_q, busy_cnt_d;
   logic [31:0] conflict_cnt_q, conflict_cnt_d;
   logic        conflict;

   // Saturating counters: transfers, and cycles where several producers compete outside flush.
   always_comb begin
      conflict       = ($countones(req_valid) > 1) && !flush;
      busy_cnt_d     = (xfer && (busy_cnt_q != '1)) ? busy_cnt_q + 32'd1 : busy_cnt_q;
      conflict_cnt_d = (conflict && (conflict_cnt_q != '1)) ? conflict_cnt_q + 32'd1 : conflict_cnt_q;
   end

   // Counter registers cleared on reset, so reset cycles are never counted.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_cnt_q     <= '0;
         conflict_cnt_q <= '0;
      end else begin
         busy_cnt_q     <= busy_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign busy_cnt     = busy_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector bench for cdb_arbiter (checks CDB_PERF_CNT_EN counters when defined)
module tb_cdb_arbiter;

   logic        clock;
   logic        reset;
   logic        flush;
   logic [2:0]  req_valid;
   logic [11:0] req_op;
   logic [8:0]  req_tag;
   logic [8:0]  req_dest;
   logic [47:0] req_data;
   logic [47:0] req_sdata;
   logic [2:0]  req_ready;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        rf_we;
   logic [2:0]  rf_addr;
   logic [15:0] rf_data;
   logic        mem_we;
   logic [5:0]  mem_addr;
   logic [15:0] mem_data;
`ifdef CDB_PERF_CNT_EN
   logic [31:0] busy_cnt;
   logic [31:0] conflict_cnt;
`endif

   int checks;
   int failures;

   cdb_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_tag   (req_tag),
      .req_dest  (req_dest),
      .req_data  (req_data),
      .req_sdata (req_sdata),
      .req_ready (req_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .rf_we     (rf_we),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data)
`ifdef CDB_PERF_CNT_EN
      ,
      .busy_cnt     (busy_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        flush;
      logic [2:0]  valid;
      logic [11:0] op;
      logic [47:0] data;
      logic [47:0] sdata;
      logic [2:0]  e_ready;
      logic        e_cv;
      logic [2:0]  e_tag;
      logic [15:0] e_data;
      logic        e_rfwe;
      logic [2:0]  e_rfaddr;
      logic [15:0] e_rfdata;
      logic        e_memwe;
      logic [5:0]  e_memaddr;
      logic [15:0] e_memdata;
   } vec_t;

   vec_t vecs[12];
   logic [2:0] stream_ready[6];
   logic [2:0] stream_tag[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string tagname, input logic cv, input logic [2:0] tg,
                           input logic [15:0] dt, input logic rw, input logic [2:0] ra,
                           input logic [15:0] rd, input logic mw, input logic [5:0] ma,
                           input logic [15:0] md);
      chk({tagname, ".cdb_valid"}, 32'(cdb_valid), 32'(cv));
      chk({tagname, ".cdb_tag"},   32'(cdb_tag),   32'(tg));
      chk({tagname, ".cdb_data"},  32'(cdb_data),  32'(dt));
      chk({tagname, ".rf_we"},     32'(rf_we),     32'(rw));
      chk({tagname, ".rf_addr"},   32'(rf_addr),   32'(ra));
      chk({tagname, ".rf_data"},   32'(rf_data),   32'(rd));
      chk({tagname, ".mem_we"},    32'(mem_we),    32'(mw));
      chk({tagname, ".mem_addr"},  32'(mem_addr),  32'(ma));
      chk({tagname, ".mem_data"},  32'(mem_data),  32'(md));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      // Fixed per-producer routing: tags p0=2 p1=4 p2=6, dests p0=5 p1=3 p2=1.
      req_tag   = {3'd6, 3'd4, 3'd2};
      req_dest  = {3'd1, 3'd3, 3'd5};
      reset     = 1'b1;
      flush     = 1'b0;
      req_valid = 3'b000;
      req_op    = '0;
      req_data  = '0;
      req_sdata = '0;

      //          flush valid   op(p2p1p0) data(p2_p1_p0)         sdata                 rdy    cv tag data      rfwe ra rfdata   mw maddr  mdata
      vecs[0]  = '{1'b0, 3'b001, 12'h000, 48'h0000_0000_1234, 48'h0,                3'b001, 1, 2, 16'h1234, 1, 5, 16'h1234, 0, 6'h00, 16'h0000};
      vecs[1]  = '{1'b0, 3'b111, 12'h241, 48'h3333_2222_1111, 48'h0,                3'b010, 1, 4, 16'h2222, 1, 3, 16'h2222, 0, 6'h00, 16'h0000};
      vecs[2]  = '{1'b0, 3'b111, 12'h241, 48'h3333_2222_1111, 48'h0,                3'b100, 1, 6, 16'h3333, 1, 1, 16'h3333, 0, 6'h00, 16'h0000};
      vecs[3]  = '{1'b0, 3'b111, 12'h241, 48'h3333_2222_1111, 48'h0,                3'b001, 1, 2, 16'h1111, 1, 5, 16'h1111, 0, 6'h00, 16'h0000};
      vecs[4]  = '{1'b0, 3'b100, 12'h300, 48'h0025_0000_0000, 48'hBEEF_0000_0000,   3'b100, 1, 6, 16'h0025, 0, 5, 16'h1111, 1, 6'h25, 16'hBEEF};
      vecs[5]  = '{1'b1, 3'b011, 12'h000, 48'h0000_BBBB_AAAA, 48'h0,                3'b000, 0, 6, 16'h0025, 0, 5, 16'h1111, 0, 6'h25, 16'hBEEF};
      vecs[6]  = '{1'b0, 3'b011, 12'h000, 48'h0000_BBBB_AAAA, 48'h0,                3'b001, 1, 2, 16'hAAAA, 1, 5, 16'hAAAA, 0, 6'h25, 16'hBEEF};
      vecs[7]  = '{1'b0, 3'b010, 12'h070, 48'h0000_5555_0000, 48'h0,                3'b010, 1, 4, 16'h5555, 0, 5, 16'hAAAA, 0, 6'h25, 16'hBEEF};
      vecs[8]  = '{1'b0, 3'b000, 12'h000, 48'h0,              48'h0,                3'b000, 0, 4, 16'h5555, 0, 5, 16'hAAAA, 0, 6'h25, 16'hBEEF};
      vecs[9]  = '{1'b0, 3'b010, 12'h000, 48'h0000_6666_0000, 48'h0,                3'b010, 1, 4, 16'h6666, 1, 3, 16'h6666, 0, 6'h25, 16'hBEEF};
      vecs[10] = '{1'b0, 3'b010, 12'h000, 48'h0000_7777_0000, 48'h0,                3'b010, 1, 4, 16'h7777, 1, 3, 16'h7777, 0, 6'h25, 16'hBEEF};
      vecs[11] = '{1'b0, 3'b101, 12'h000, 48'h0202_0000_0101, 48'h0,                3'b100, 1, 6, 16'h0202, 1, 1, 16'h0202, 0, 6'h25, 16'hBEEF};

      stream_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      stream_tag   = '{3'd2, 3'd4, 3'd6, 3'd2, 3'd4, 3'd6};

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("reset.req_ready", 32'(req_ready), 32'h0);
      chk_outs("reset", 0, 0, 16'h0, 0, 0, 16'h0, 0, 6'h0, 16'h0);
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         flush     = vecs[i].flush;
         req_valid = vecs[i].valid;
         req_op    = vecs[i].op;
         req_data  = vecs[i].data;
         req_sdata = vecs[i].sdata;
         #1;
         chk($sformatf("v%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
         @(posedge clock);
         #1;
         chk_outs($sformatf("v%0d", i), vecs[i].e_cv, vecs[i].e_tag, vecs[i].e_data,
                  vecs[i].e_rfwe, vecs[i].e_rfaddr, vecs[i].e_rfdata,
                  vecs[i].e_memwe, vecs[i].e_memaddr, vecs[i].e_memdata);
      end

      // Three-way stream after reset: 0,1,2,0,1,2 with continuous cdb_valid
      flush     = 1'b0;
      req_valid = 3'b000;
      reset     = 1'b1;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      req_valid = 3'b111;
      req_op    = 12'h000;
      req_data  = 48'h3333_2222_1111;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("stream%0d.req_ready", c), 32'(req_ready), 32'(stream_ready[c]));
         @(posedge clock);
         #1;
         chk($sformatf("stream%0d.cdb_valid", c), 32'(cdb_valid), 32'h1);
         chk($sformatf("stream%0d.cdb_tag", c), 32'(cdb_tag), 32'(stream_tag[c]));
      end
      req_valid = 3'b000;
`ifdef CDB_PERF_CNT_EN
      chk("perf.busy_cnt", busy_cnt, 32'd6);
      chk("perf.conflict_cnt", conflict_cnt, 32'd6);
`endif
      @(posedge clock);
      #1;
      chk("stream_end.cdb_valid", 32'(cdb_valid), 32'h0);

      // Reset in the middle of a stream
      req_valid = 3'b111;
      req_data  = 48'h3333_2222_1111;
      #1;
      chk("mid.first_ready", 32'(req_ready), 32'b001);
      @(posedge clock);
      #1;
      chk("mid.second_ready", 32'(req_ready), 32'b010);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      chk("mid.ready_in_reset", 32'(req_ready), 32'h0);
      @(posedge clock);
      #1;
      chk_outs("mid_reset", 0, 0, 16'h0, 0, 0, 16'h0, 0, 6'h0, 16'h0);
`ifdef CDB_PERF_CNT_EN
      chk("mid.busy_cnt", busy_cnt, 32'd0);
      chk("mid.conflict_cnt", conflict_cnt, 32'd0);
`endif
      reset = 1'b0;
      #1;
      chk("mid.ready_after_reset", 32'(req_ready), 32'b001);
      @(posedge clock);
      #1;
      chk("mid.cdb_valid_after", 32'(cdb_valid), 32'h1);
      chk("mid.cdb_tag_after", 32'(cdb_tag), 32'd2);
      chk("mid.cdb_data_after", 32'(cdb_data), 32'h1111);
      req_valid = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter and sequencer for the Common Data Bus of the Tomasulo core.
- Accepts completed results from NUM_REQ producers (adder RS, multiplier RS, load/store unit) and grants the bus to one producer per cycle.
- Drives a registered CDB broadcast (tag + data) to all reservation stations.
- Generates FP register-file write and data-memory store strobes from the granted result's opcode.

Parameters:
- NUM_REQ, 3, number of producers requesting the CDB (2..8).
- DATA_W, 16, result/data width.
- TAG_W, 3, reservation-station tag width.
- REG_AW, 3, FP register address width.
- MEM_AW, 6, data memory address width (64 words).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash: no grant this cycle, next broadcast invalid.
- req_valid  in  NUM_REQ  producer i has a completed result.
- req_op  in  4*NUM_REQ  opcode per producer, slice i = [4i+3:4i].
- req_tag  in  TAG_W*NUM_REQ  RS tag per producer.
- req_dest  in  REG_AW*NUM_REQ  destination FP register per producer.
- req_data  in  DATA_W*NUM_REQ  result value; store address for sd.
- req_sdata  in  DATA_W*NUM_REQ  store value (used only for sd).
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast value.
- rf_we  out  1  FP register write enable.
- rf_addr  out  REG_AW  FP register write address.
- rf_data  out  DATA_W  FP register write data.
- mem_we  out  1  data-memory store enable.
- mem_addr  out  MEM_AW  store address.
- mem_data  out  DATA_W  store data.

Behaviour:
- Reset values: all outputs 0; round-robin pointer = NUM_REQ-1, so producer 0 has first priority.
- Grant rule:
  - req_ready is combinational: at most one bit set, and only among set req_valid bits.
  - Search starts at pointer+1 and wraps modulo NUM_REQ.
  - No grant while reset or flush is high.
- Handshake: a transfer occurs on a clock edge where req_valid[i] and req_ready[i] are both 1. Producers hold valid, op, tag, dest, data and sdata stable until granted.
- Pointer update: on a transfer, pointer becomes the granted index. With no transfer, the pointer holds.
- Latency: one cycle. Outputs are registered on the transfer edge; cdb_valid is high for exactly one cycle per transfer.
- Back-to-back transfers are allowed. A continuous stream of requests yields continuous cdb_valid.
- Opcode decode, registered with the broadcast:
  - 0000 add, 0001 sub, 0100 mul, 0010 ld: rf_we=1, rf_addr=dest, rf_data=data, mem_we=0.
  - 0011 sd: mem_we=1, mem_addr=data[MEM_AW-1:0], mem_data=sdata, rf_we=0. cdb_valid is still 1 so dependent RSs release the tag.
  - Any other opcode: cdb_valid=1, rf_we=0, mem_we=0.
- On cycles with no transfer: cdb_valid, rf_we and mem_we are 0. Data/tag/address outputs hold their last values.
- Flush: the edge where flush=1 clears cdb_valid, rf_we and mem_we, and leaves the pointer unchanged.
- Reset mid-operation: outputs and pointer return to reset values on the next edge. A pending request is not lost; it is re-arbitrated after reset deasserts.
- Single requester: that requester is granted every cycle it is valid, whatever the pointer value.

Optional Feature:
- Macro CDB_PERF_CNT_EN.
- When defined, adds two outputs:
  - busy_cnt (32 bits): increments on every transfer.
  - conflict_cnt (32 bits): increments on every cycle in which two or more req_valid bits are set and no flush or reset is active.
- Both counters clear on reset and saturate at all-ones.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then req_valid=001, op=0000, tag=2, dest=5, data=16'h1234 -> req_ready=001. Next cycle: cdb_valid=1, cdb_tag=2, rf_we=1, rf_addr=5, rf_data=16'h1234.
- All three valid and held for 6 cycles after reset -> grants 0,1,2,0,1,2 and cdb_valid high 6 consecutive cycles.
- Producer 2 sends sd with data=16'h0025, sdata=16'hBEEF -> mem_we=1, mem_addr=6'h25, mem_data=16'hBEEF, rf_we=0, cdb_valid=1.
- Requests 011 with flush=1 for one cycle -> req_ready=000, next cycle cdb_valid=0, pointer unchanged. After flush drops, producer 0 is granted.
- Reset asserted in the middle of round-robin streaming -> all outputs 0 the next cycle; after release, producer 0 is granted first.
- With CDB_PERF_CNT_EN defined, run the 6-cycle three-requester stream -> busy_cnt=6, conflict_cnt=6.
